core_common_stage: RTL and testbench
====================================

CORE_COMMON_STAGE -- requirements
Module: core_common_stage

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- TRIG_ID_W, 5, trigger-ID width
- LAT_W, 9, latency-counter width
- CONF_ADDR_W, 12, config address width
- DATA_W, 8, config data width
- HITOR_W, 4, HitOr lanes
- CORE_ADDR_W, 6, core address width; SHALL be <= CONF_ADDR_W-1
- CONF_WORDS, 2, local config registers; SHALL be >= 1 and <= 2^(CONF_ADDR_W-CORE_ADDR_W)
- DEF_VAL, 8'h00, DefConf load value
REQ-002 SHALL have ports, one per line (name, direction, width, meaning); clock and reset first:
- Clk, in, 1, sole clock
- Reset, in, 1, asynchronous, active-high
- L1Trig/CalEdge/CalAux/DefConf/Read, in, 1 each, broadcasts
- TrigId, in, TRIG_ID_W, trigger ID
- LatCnt, in, LAT_W, latency count
- AddressIn, in, CORE_ADDR_W, this core's chain address
- AddressConfIn, in, CONF_ADDR_W, config address
- DataConfWrIn, in, DATA_W, write data
- ConfWrIn, in, 1, write strobe
- DataConfRdIn, in, DATA_W, upstream read data
- HitOrIn, in, HITOR_W, upstream HitOr
- LocalHitOr, in, HITOR_W, this core's HitOr
- TokIn, in, 1, upstream data-pending token
- LocalPending, in, 1, this core has hits
- ReadDone, in, 1, local readout complete
- *Out versions of every broadcast, TrigId, LatCnt, AddressConf, DataConfWr, ConfWr, out, same widths, registered copies
- AddressOut, out, CORE_ADDR_W, next core address
- DataConfRdOut, out, DATA_W, read data
- HitOrOut, out, HITOR_W, merged HitOr
- TokOut, out, 1, token
- LocalRead, out, 1, readout grant
- ConfReg, out, CONF_WORDS*DATA_W, local config (word 0 in LSBs)
- OutLo, out, 1, constant 0

Function
REQ-003 Every broadcast, TrigId, LatCnt, AddressConf, DataConfWr and ConfWr output SHALL equal its input delayed by exactly one Clk cycle.
REQ-004 AddressOut SHALL be registered AddressIn+1, modulo 2^CORE_ADDR_W (all-ones wraps to 0).
REQ-005 HitOrOut SHALL be registered (HitOrIn | LocalHitOr), bitwise, one-cycle latency.
REQ-006 TokOut SHALL be registered (TokIn | LocalPending), one-cycle latency.
REQ-007 Local hit: AddressConfIn[CONF_ADDR_W-1 -: CORE_ADDR_W] == AddressIn, with word index w = AddressConfIn[CONF_ADDR_W-CORE_ADDR_W-1:0] < CONF_WORDS.
REQ-008 A write SHALL occur only on the cycle the ConfWrIn rising edge is detected (ConfWrIn=1, previous sample 0) with a local hit; DataConfWrIn goes to word w, visible on ConfReg the next cycle. A held ConfWrIn SHALL NOT rewrite.
REQ-009 DefConf=1 SHALL load DEF_VAL into all words next cycle, taking priority over a simultaneous write.
REQ-010 DataConfRdOut SHALL be registered word w on a local hit, else registered DataConfRdIn.
REQ-011 Readout FSM states:
- IDLE -> GRANT when Read & LocalPending & !TokIn.
- GRANT: LocalRead=1 (Moore, registered); -> WAIT_CLR on ReadDone.
- WAIT_CLR: LocalRead=0; -> IDLE when Read=0.
- Read dropping in GRANT -> IDLE.
REQ-012 Upstream priority: TokIn=1 in IDLE SHALL block the grant; TokIn rising during GRANT SHALL NOT revoke it.

Reset
REQ-013 While Reset=1 (asynchronous), all registered outputs, the edge-detect flop and ConfReg SHALL be 0, and the FSM SHALL be IDLE; DEF_VAL is loaded only via DefConf.
REQ-014 Reset during GRANT SHALL drop LocalRead immediately; after release, operation SHALL restart from IDLE with no residual write.

Verification
REQ-015 Bench SHALL cover:
- AddressIn=6'h3F, TrigId=5'h1A, L1Trig pulse -> AddressOut=0; L1TrigOut/TrigIdOut=5'h1A exactly one cycle later.
- AddressIn=3, AddressConfIn=12'h0C1, DataConfWrIn=8'hA5, ConfWrIn held 4 cycles -> word1=8'hA5, single write; with DataConfWrIn changed to 8'h5A mid-hold, word1 stays 8'hA5.
- AddressConfIn=12'h081 with AddressIn=3 -> no write; DataConfRdOut = DataConfRdIn (8'h77).
- DefConf and local write same cycle, DEF_VAL=8'h3C -> all words 8'h3C.
- Read=1, LocalPending=1, TokIn=1 -> LocalRead stays 0; TokIn->0 -> LocalRead=1 next cycle; ReadDone -> LocalRead=0; Read=0 -> IDLE.
- Reset asserted in GRANT -> LocalRead, TokOut, HitOrOut, ConfReg = 0 without a clock edge.

Source files
------------

// File: rtl/core_common_stage.sv
// core_common_stage: one link of a daisy-chained pixel-core column.
// Re-times the broadcast/config buses to the next core, increments the chain
// address, merges HitOr and the data-pending token, holds a small bank of
// locally addressed config registers, and arbitrates the local readout grant.
module core_common_stage #(
    parameter int TRIG_ID_W   = 5,    // trigger-ID width
    parameter int LAT_W       = 9,    // latency-counter width
    parameter int CONF_ADDR_W = 12,   // config address width
    parameter int DATA_W      = 8,    // config data width
    parameter int HITOR_W     = 4,    // HitOr lanes
    parameter int CORE_ADDR_W = 6,    // core address width, must be <= CONF_ADDR_W-1
    parameter int CONF_WORDS  = 2,    // local config words, 1 .. 2^(CONF_ADDR_W-CORE_ADDR_W)
    parameter logic [DATA_W-1:0] DEF_VAL = 8'h00  // value loaded by DefConf
) (
    input  logic                          Clk,
    input  logic                          Reset,
    // broadcasts
    input  logic                          L1Trig,
    input  logic                          CalEdge,
    input  logic                          CalAux,
    input  logic                          DefConf,
    input  logic                          Read,
    input  logic [TRIG_ID_W-1:0]          TrigId,
    input  logic [LAT_W-1:0]              LatCnt,
    // chain address and config bus
    input  logic [CORE_ADDR_W-1:0]        AddressIn,
    input  logic [CONF_ADDR_W-1:0]        AddressConfIn,
    input  logic [DATA_W-1:0]             DataConfWrIn,
    input  logic                          ConfWrIn,
    input  logic [DATA_W-1:0]             DataConfRdIn,
    // hit / readout chain
    input  logic [HITOR_W-1:0]            HitOrIn,
    input  logic [HITOR_W-1:0]            LocalHitOr,
    input  logic                          TokIn,
    input  logic                          LocalPending,
    input  logic                          ReadDone,
    // re-timed copies for the next core
    output logic                          L1TrigOut,
    output logic                          CalEdgeOut,
    output logic                          CalAuxOut,
    output logic                          DefConfOut,
    output logic                          ReadOut,
    output logic [TRIG_ID_W-1:0]          TrigIdOut,
    output logic [LAT_W-1:0]              LatCntOut,
    output logic [CONF_ADDR_W-1:0]        AddressConfOut,
    output logic [DATA_W-1:0]             DataConfWrOut,
    output logic                          ConfWrOut,
    output logic [CORE_ADDR_W-1:0]        AddressOut,
    output logic [DATA_W-1:0]             DataConfRdOut,
    output logic [HITOR_W-1:0]            HitOrOut,
    output logic                          TokOut,
    output logic                          LocalRead,
    output logic [CONF_WORDS*DATA_W-1:0]  ConfReg,
    output logic                          OutLo,
    // readout FSM state, for observation only
    output logic [1:0]                    DbgState
);

    localparam int WIDX_W = CONF_ADDR_W - CORE_ADDR_W;
    localparam logic [WIDX_W:0] NUM_WORDS = (WIDX_W+1)'(CONF_WORDS);

    // Readout handshake: while Read is high and this core has hits
    // (LocalPending) and no upstream core holds the token (TokIn low), the
    // core is granted (LocalRead high). The grant is held until ReadDone, then
    // LocalRead drops and the core waits for Read to go low before it can be
    // granted again. Read falling at any time returns the arbiter to idle.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_WAIT_CLR = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_local_read;

    logic                      r_l1trig;
    logic                      r_cal_edge;
    logic                      r_cal_aux;
    logic                      r_def_conf;
    logic                      r_read;
    logic [TRIG_ID_W-1:0]      r_trig_id;
    logic [LAT_W-1:0]          r_lat_cnt;
    logic [CONF_ADDR_W-1:0]    r_addr_conf;
    logic [DATA_W-1:0]         r_data_wr;
    logic                      r_conf_wr;
    logic [CORE_ADDR_W-1:0]    r_addr_out;
    logic [DATA_W-1:0]         r_data_rd;
    logic [HITOR_W-1:0]        r_hitor;
    logic                      r_tok;
    logic                      r_conf_wr_prev;
    logic [DATA_W-1:0]         r_conf [CONF_WORDS];

    logic [CORE_ADDR_W-1:0]    w_conf_core;
    logic [WIDX_W-1:0]         w_word_idx;
    logic                      w_local_hit;
    logic                      w_wr_edge;
    logic                      w_wr_en;
    logic [DATA_W-1:0]         w_rd_word;

    // Decode the config address into the target core and word index.
    assign w_conf_core = AddressConfIn[CONF_ADDR_W-1 -: CORE_ADDR_W];
    assign w_word_idx  = AddressConfIn[WIDX_W-1:0];
    assign w_local_hit = (w_conf_core == AddressIn) && ({1'b0, w_word_idx} < NUM_WORDS);
    // Only the first cycle of a write strobe counts, so a held strobe writes once.
    assign w_wr_edge   = ConfWrIn && !r_conf_wr_prev;
    assign w_wr_en     = w_wr_edge && w_local_hit;

    // Select the addressed local word for the read-back path.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < CONF_WORDS; i++) begin
            if (w_word_idx == WIDX_W'(i)) begin
                w_rd_word = r_conf[i];
            end
        end
    end

    // Re-time broadcasts, config bus, chain address, HitOr, token and read data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_l1trig       <= 1'b0;
            r_cal_edge     <= 1'b0;
            r_cal_aux      <= 1'b0;
            r_def_conf     <= 1'b0;
            r_read         <= 1'b0;
            r_trig_id      <= '0;
            r_lat_cnt      <= '0;
            r_addr_conf    <= '0;
            r_data_wr      <= '0;
            r_conf_wr      <= 1'b0;
            r_addr_out     <= '0;
            r_data_rd      <= '0;
            r_hitor        <= '0;
            r_tok          <= 1'b0;
            r_conf_wr_prev <= 1'b0;
        end else begin
            r_l1trig       <= L1Trig;
            r_cal_edge     <= CalEdge;
            r_cal_aux      <= CalAux;
            r_def_conf     <= DefConf;
            r_read         <= Read;
            r_trig_id      <= TrigId;
            r_lat_cnt      <= LatCnt;
            r_addr_conf    <= AddressConfIn;
            r_data_wr      <= DataConfWrIn;
            r_conf_wr      <= ConfWrIn;
            // Wraps naturally from all-ones to zero.
            r_addr_out     <= AddressIn + {{(CORE_ADDR_W-1){1'b0}}, 1'b1};
            r_data_rd      <= w_local_hit ? w_rd_word : DataConfRdIn;
            r_hitor        <= HitOrIn | LocalHitOr;
            r_tok          <= TokIn | LocalPending;
            r_conf_wr_prev <= ConfWrIn;
        end
    end

    // Local config bank: DefConf overrides any write in the same cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < CONF_WORDS; i++) begin
                r_conf[i] <= '0;
            end
        end else if (DefConf) begin
            for (int i = 0; i < CONF_WORDS; i++) begin
                r_conf[i] <= DEF_VAL;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < CONF_WORDS; i++) begin
                if (w_word_idx == WIDX_W'(i)) begin
                    r_conf[i] <= DataConfWrIn;
                end
            end
        end
    end

    // Readout FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // An upstream token blocks the grant.
                if (Read && LocalPending && !TokIn) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // TokIn is ignored here: a grant once given is not revoked.
                if (!Read) begin
                    w_state_next = ST_IDLE;
                end else if (ReadDone) begin
                    w_state_next = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                if (!Read) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Readout FSM state register and registered grant output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_local_read <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_local_read <= (w_state_next == ST_GRANT);
        end
    end

    // Flatten the config bank, word 0 in the LSBs.
    genvar g;
    generate
        for (g = 0; g < CONF_WORDS; g++) begin : g_conf_out
            assign ConfReg[g*DATA_W +: DATA_W] = r_conf[g];
        end
    endgenerate

    assign L1TrigOut      = r_l1trig;
    assign CalEdgeOut     = r_cal_edge;
    assign CalAuxOut      = r_cal_aux;
    assign DefConfOut     = r_def_conf;
    assign ReadOut        = r_read;
    assign TrigIdOut      = r_trig_id;
    assign LatCntOut      = r_lat_cnt;
    assign AddressConfOut = r_addr_conf;
    assign DataConfWrOut  = r_data_wr;
    assign ConfWrOut      = r_conf_wr;
    assign AddressOut     = r_addr_out;
    assign DataConfRdOut  = r_data_rd;
    assign HitOrOut       = r_hitor;
    assign TokOut         = r_tok;
    assign LocalRead      = r_local_read;
    assign OutLo          = 1'b0;
    assign DbgState       = r_state;

endmodule

// File: tb/tb_core_common_stage.sv
// Testbench for core_common_stage: vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_core_common_stage;

    localparam int TRIG_ID_W   = 5;
    localparam int LAT_W       = 9;
    localparam int CONF_ADDR_W = 12;
    localparam int DATA_W      = 8;
    localparam int HITOR_W     = 4;
    localparam int CORE_ADDR_W = 6;
    localparam int CONF_WORDS  = 2;
    localparam logic [7:0] DEF_VAL = 8'h3C;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        L1Trig, CalEdge, CalAux, DefConf, Read;
    logic [4:0]  TrigId;
    logic [8:0]  LatCnt;
    logic [5:0]  AddressIn;
    logic [11:0] AddressConfIn;
    logic [7:0]  DataConfWrIn;
    logic        ConfWrIn;
    logic [7:0]  DataConfRdIn;
    logic [3:0]  HitOrIn, LocalHitOr;
    logic        TokIn, LocalPending, ReadDone;

    logic        L1TrigOut, CalEdgeOut, CalAuxOut, DefConfOut, ReadOut;
    logic [4:0]  TrigIdOut;
    logic [8:0]  LatCntOut;
    logic [11:0] AddressConfOut;
    logic [7:0]  DataConfWrOut;
    logic        ConfWrOut;
    logic [5:0]  AddressOut;
    logic [7:0]  DataConfRdOut;
    logic [3:0]  HitOrOut;
    logic        TokOut, LocalRead;
    logic [15:0] ConfReg;
    logic        OutLo;
    logic [1:0]  DbgState;

    int checks = 0;
    int errors = 0;

    core_common_stage #(
        .TRIG_ID_W(TRIG_ID_W), .LAT_W(LAT_W), .CONF_ADDR_W(CONF_ADDR_W),
        .DATA_W(DATA_W), .HITOR_W(HITOR_W), .CORE_ADDR_W(CORE_ADDR_W),
        .CONF_WORDS(CONF_WORDS), .DEF_VAL(DEF_VAL)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .L1Trig(L1Trig), .CalEdge(CalEdge), .CalAux(CalAux), .DefConf(DefConf), .Read(Read),
        .TrigId(TrigId), .LatCnt(LatCnt), .AddressIn(AddressIn), .AddressConfIn(AddressConfIn),
        .DataConfWrIn(DataConfWrIn), .ConfWrIn(ConfWrIn), .DataConfRdIn(DataConfRdIn),
        .HitOrIn(HitOrIn), .LocalHitOr(LocalHitOr), .TokIn(TokIn), .LocalPending(LocalPending),
        .ReadDone(ReadDone),
        .L1TrigOut(L1TrigOut), .CalEdgeOut(CalEdgeOut), .CalAuxOut(CalAuxOut),
        .DefConfOut(DefConfOut), .ReadOut(ReadOut), .TrigIdOut(TrigIdOut), .LatCntOut(LatCntOut),
        .AddressConfOut(AddressConfOut), .DataConfWrOut(DataConfWrOut), .ConfWrOut(ConfWrOut),
        .AddressOut(AddressOut), .DataConfRdOut(DataConfRdOut), .HitOrOut(HitOrOut),
        .TokOut(TokOut), .LocalRead(LocalRead), .ConfReg(ConfReg), .OutLo(OutLo),
        .DbgState(DbgState)
    );

    // clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver / check tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        L1Trig = 0; CalEdge = 0; CalAux = 0; DefConf = 0; Read = 0;
        TrigId = '0; LatCnt = '0; AddressIn = '0; AddressConfIn = 12'hFFF;
        DataConfWrIn = '0; ConfWrIn = 0; DataConfRdIn = '0;
        HitOrIn = '0; LocalHitOr = '0; TokIn = 0; LocalPending = 0; ReadDone = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bcast"}, {L1TrigOut, CalEdgeOut, CalAuxOut, DefConfOut, ReadOut, ConfWrOut}, 0);
        check({tag, "_buses"}, {TrigIdOut, LatCntOut, AddressConfOut, DataConfWrOut}, 0);
        check({tag, "_addr_out"}, AddressOut, 0);
        check({tag, "_rd_out"}, DataConfRdOut, 0);
        check({tag, "_hitor"}, HitOrOut, 0);
        check({tag, "_tok"}, TokOut, 0);
        check({tag, "_local_read"}, LocalRead, 0);
        check({tag, "_conf_reg"}, ConfReg, 0);
        check({tag, "_out_lo"}, OutLo, 0);
    endtask

    typedef struct {
        logic [5:0] addr_in;
        logic [3:0] hor_in;
        logic [3:0] hor_loc;
        logic       tok_in;
        logic       pend;
        logic [7:0] rd_in;
        logic [4:0] trig;
        logic [5:0] exp_addr;
        logic [3:0] exp_hor;
        logic       exp_tok;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    // behavioural model state for the random phase
    logic [7:0] m_conf [CONF_WORDS];
    logic       m_prev_wr;
    bit         m_granted;
    bit         m_done_wait;

    initial begin
        clear_inputs();
        Reset = 1;
        step();
        step();
        check_all_zero("reset");

        #1 Reset = 0;
        step();

        // single-cycle pass-through functions
        vecs[0] = '{6'h00, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 5'h00, 6'h01, 4'h0, 1'b0, 8'h00};
        vecs[1] = '{6'h3F, 4'h5, 4'h0, 1'b1, 1'b0, 8'h77, 5'h1A, 6'h00, 4'h5, 1'b1, 8'h77};
        vecs[2] = '{6'h1F, 4'h0, 4'hA, 1'b0, 1'b1, 8'hC3, 5'h05, 6'h20, 4'hA, 1'b1, 8'hC3};
        vecs[3] = '{6'h3E, 4'h9, 4'h6, 1'b1, 1'b1, 8'hFF, 5'h1F, 6'h3F, 4'hF, 1'b1, 8'hFF};
        vecs[4] = '{6'h2A, 4'hF, 4'hF, 1'b0, 1'b0, 8'h3C, 5'h00, 6'h2B, 4'hF, 1'b0, 8'h3C};
        vecs[5] = '{6'h3F, 4'h0, 4'h0, 1'b0, 1'b0, 8'h01, 5'h11, 6'h00, 4'h0, 1'b0, 8'h01};
        for (int i = 0; i < 6; i++) begin
            AddressIn = vecs[i].addr_in; HitOrIn = vecs[i].hor_in; LocalHitOr = vecs[i].hor_loc;
            TokIn = vecs[i].tok_in; LocalPending = vecs[i].pend; DataConfRdIn = vecs[i].rd_in;
            TrigId = vecs[i].trig;
            step();
            check("vec_addr_out", AddressOut, vecs[i].exp_addr);
            check("vec_hitor", HitOrOut, vecs[i].exp_hor);
            check("vec_tok", TokOut, vecs[i].exp_tok);
            check("vec_rd_out", DataConfRdOut, vecs[i].exp_rd);
            check("vec_trig_id", TrigIdOut, vecs[i].trig);
        end
        clear_inputs();
        step();

        // trigger re-timing with address wrap
        AddressIn = 6'h3F; TrigId = 5'h1A; L1Trig = 1;
        #1 check("l1_not_early", L1TrigOut, 0);
        step();
        check("wrap_addr_out", AddressOut, 0);
        check("l1_out", L1TrigOut, 1);
        check("l1_trig_id", TrigIdOut, 5'h1A);
        L1Trig = 0;
        step();
        check("l1_one_cycle", L1TrigOut, 0);

        // held write strobe writes once
        AddressIn = 6'd3; AddressConfIn = 12'h0C1; DataConfWrIn = 8'hA5; ConfWrIn = 1;
        step();
        check("wr_first", ConfReg, 16'hA500);
        DataConfWrIn = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wr_held", ConfReg, 16'hA500);
        end
        check("rd_local_word", DataConfRdOut, 8'hA5);
        ConfWrIn = 0;
        step();

        // non-local address: no write, read data passes through
        AddressConfIn = 12'h081; DataConfWrIn = 8'h11; DataConfRdIn = 8'h77; ConfWrIn = 1;
        step();
        check("remote_no_write", ConfReg, 16'hA500);
        check("remote_rd_pass", DataConfRdOut, 8'h77);
        ConfWrIn = 0;
        step();

        // DefConf beats a simultaneous local write
        AddressConfIn = 12'h0C0; DataConfWrIn = 8'h99; ConfWrIn = 1; DefConf = 1;
        step();
        check("defconf_prio", ConfReg, 16'h3C3C);
        check("defconf_out", DefConfOut, 1);
        clear_inputs();
        step();

        // readout arbitration
        Read = 1; LocalPending = 1; TokIn = 1;
        step();
        check("tok_blocks_1", LocalRead, 0);
        step();
        check("tok_blocks_2", LocalRead, 0);
        check("tok_out", TokOut, 1);
        TokIn = 0;
        step();
        check("grant", LocalRead, 1);
        TokIn = 1;
        step();
        check("grant_kept", LocalRead, 1);
        TokIn = 0; ReadDone = 1;
        step();
        check("done_drop", LocalRead, 0);
        ReadDone = 0;
        step();
        check("wait_clr_hold", LocalRead, 0);
        Read = 0;
        step();
        check("back_idle", LocalRead, 0);
        Read = 1;
        step();
        check("regrant", LocalRead, 1);
        Read = 0;
        step();
        check("read_drop", LocalRead, 0);
        Read = 1;
        step();
        check("grant_before_rst", LocalRead, 1);

        // asynchronous reset in GRANT
        HitOrIn = 4'h5; TokIn = 1;
        step();
        check("pre_rst_hitor", HitOrOut, 4'h5);
        check("pre_rst_grant", LocalRead, 1);
        #2 Reset = 1;
        #1;
        check_all_zero("async_rst");
        check("async_rst_state", DbgState, 0);
        step();
        clear_inputs();
        Reset = 0;
        Read = 1; LocalPending = 1;
        step();
        check("restart_grant", LocalRead, 1);
        check("restart_conf", ConfReg, 0);

        // randomized traffic against the model
        clear_inputs();
        Reset = 1;
        step();
        Reset = 0;
        for (int i = 0; i < CONF_WORDS; i++) m_conf[i] = '0;
        m_prev_wr = 0; m_granted = 0; m_done_wait = 0;
        for (int n = 0; n < 500; n++) begin
            logic [5:0]  core_sel;
            int          w;
            bit          hit;
            logic [7:0]  e_rd;
            logic [5:0]  e_addr;
            logic [3:0]  e_hor;
            logic        e_tok;
            logic [4:0]  e_trig;
            logic [8:0]  e_lat;
            logic [11:0] e_ac;
            logic [7:0]  e_wd;
            logic [5:0]  e_bc;
            L1Trig = 1'($urandom); CalEdge = 1'($urandom); CalAux = 1'($urandom);
            DefConf = ($urandom_range(0, 15) == 0);
            Read = ($urandom_range(0, 9) < 7);
            TrigId = 5'($urandom); LatCnt = 9'($urandom);
            AddressIn = 6'($urandom);
            core_sel = $urandom_range(0, 1) ? AddressIn : 6'($urandom);
            w = $urandom_range(0, 3);
            AddressConfIn = {core_sel, 6'(w)};
            DataConfWrIn = 8'($urandom); ConfWrIn = 1'($urandom);
            DataConfRdIn = 8'($urandom);
            HitOrIn = 4'($urandom); LocalHitOr = 4'($urandom);
            TokIn = ($urandom_range(0, 9) < 3); LocalPending = 1'($urandom);
            ReadDone = ($urandom_range(0, 9) < 3);

            hit    = (core_sel == AddressIn) && (w < CONF_WORDS);
            e_rd   = hit ? m_conf[w] : DataConfRdIn;
            e_addr = 6'((int'(AddressIn) + 1) % 64);
            e_hor  = HitOrIn | LocalHitOr;
            e_tok  = TokIn | LocalPending;
            e_trig = TrigId; e_lat = LatCnt; e_ac = AddressConfIn; e_wd = DataConfWrIn;
            e_bc   = {L1Trig, CalEdge, CalAux, DefConf, Read, ConfWrIn};
            if (DefConf) begin
                for (int k = 0; k < CONF_WORDS; k++) m_conf[k] = DEF_VAL;
            end else if (ConfWrIn && !m_prev_wr && hit) begin
                m_conf[w] = DataConfWrIn;
            end
            m_prev_wr = ConfWrIn;
            if (!Read) begin
                m_granted = 0; m_done_wait = 0;
            end else if (m_granted) begin
                if (ReadDone) begin
                    m_granted = 0; m_done_wait = 1;
                end
            end else if (!m_done_wait && LocalPending && !TokIn) begin
                m_granted = 1;
            end

            step();
            check("rnd_bcast", {L1TrigOut, CalEdgeOut, CalAuxOut, DefConfOut, ReadOut, ConfWrOut}, e_bc);
            check("rnd_buses", {TrigIdOut, LatCntOut, AddressConfOut, DataConfWrOut},
                  {e_trig, e_lat, e_ac, e_wd});
            check("rnd_addr_out", AddressOut, e_addr);
            check("rnd_rd_out", DataConfRdOut, e_rd);
            check("rnd_hitor", HitOrOut, e_hor);
            check("rnd_tok", TokOut, e_tok);
            check("rnd_conf_reg", ConfReg, {m_conf[1], m_conf[0]});
            check("rnd_local_read", LocalRead, m_granted);
            check("rnd_out_lo", OutLo, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
